// File: rtl/mp_adder_arbiter_pkg.sv
// Shared definitions for the mp_adder round-robin scheduler: FSM encoding and pointer sizing.
package mp_adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } stateT;

  // clog2 of the requester count, never narrower than one bit
  function automatic int ptrWidth(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

endpackage

// File: rtl/mp_adder.sv
// Multi-precision adder: adds one ADDER_WIDTH slice per cycle, pulses oDone with the full sum and carry.
module mp_adder #(
  parameter int OPERAND_WIDTH = 128,
  parameter int ADDER_WIDTH   = 16
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iStart,
  input  logic [OPERAND_WIDTH-1:0] iA,
  input  logic [OPERAND_WIDTH-1:0] iB,
  output logic [OPERAND_WIDTH:0] oRes,
  output logic                   oDone
);

  localparam int NUM_SLICES = OPERAND_WIDTH / ADDER_WIDTH;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  logic [OPERAND_WIDTH-1:0] aQ, bQ, sumQ;
  logic [ADDER_WIDTH:0]     sliceSum;
  logic [CNT_W-1:0]         cnt;
  logic                     carryQ;
  logic                     busy;

  // Lowest remaining slice plus the carry from the previous slice
  always_comb begin
    sliceSum = {1'b0, aQ[ADDER_WIDTH-1:0]} + {1'b0, bQ[ADDER_WIDTH-1:0]}
             + {{ADDER_WIDTH{1'b0}}, carryQ};
  end

  // Operands shift down one slice per cycle; finished slices shift into the top of sumQ
  always_ff @(posedge iClk) begin
    if (iRst) begin
      aQ     <= '0;
      bQ     <= '0;
      sumQ   <= '0;
      carryQ <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      oDone  <= 1'b0;
      oRes   <= '0;
    end else if (iStart) begin
      aQ     <= iA;
      bQ     <= iB;
      sumQ   <= '0;
      carryQ <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b1;
      oDone  <= 1'b0;
    end else if (busy) begin
      aQ     <= aQ >> ADDER_WIDTH;
      bQ     <= bQ >> ADDER_WIDTH;
      sumQ   <= {sliceSum[ADDER_WIDTH-1:0], sumQ[OPERAND_WIDTH-1:ADDER_WIDTH]};
      carryQ <= sliceSum[ADDER_WIDTH];
      cnt    <= cnt + CNT_W'(1);
      if (cnt == LAST_SLICE) begin
        busy  <= 1'b0;
        oDone <= 1'b1;
        oRes  <= {sliceSum, sumQ[OPERAND_WIDTH-1:ADDER_WIDTH]};
      end else begin
        oDone <= 1'b0;
      end
    end else begin
      oDone <= 1'b0;
    end
  end

endmodule

// File: rtl/mp_adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after iPtr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] iReq,
  input  logic [PTR_W-1:0]   iPtr,
  output logic [NUM_REQ-1:0] oGrant,
  output logic [PTR_W-1:0]   oIdx,
  output logic               oAny
);

  int   idx;
  logic hit;

  // Walk the requesters in priority order; only the first hit is recorded
  always_comb begin
    oGrant = '0;
    oIdx   = '0;
    oAny   = 1'b0;
    idx    = 0;
    hit    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx         = (int'(iPtr) + i) % NUM_REQ;
      hit         = ~oAny & iReq[idx];
      oGrant[idx] = oGrant[idx] | hit;
      oIdx        = hit ? PTR_W'(idx) : oIdx;
      oAny        = oAny | hit;
    end
  end

endmodule

// File: rtl/mp_adder_arbiter.sv
// Shares one mp_adder among NUM_REQ requesters: round-robin grant, operand capture,
// start pulse, and a one-hot tagged result.
module mp_adder_arbiter
  import mp_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int OPERAND_WIDTH = 128,
  parameter int ADDER_WIDTH   = 16
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic [NUM_REQ-1:0]             iReq,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] iOpA,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] iOpB,
  output logic [NUM_REQ-1:0]             oGrant,
  output logic [OPERAND_WIDTH:0]         oRes,
  output logic [NUM_REQ-1:0]             oValid,
  output logic                           oBusy
);

  localparam int PTR_W = ptrWidth(NUM_REQ);
  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  stateT                    state, stateNext;
  logic [PTR_W-1:0]         ptr, wQ, arbIdx;
  logic [NUM_REQ-1:0]       arbGrant;
  logic                     arbAny;
  logic [OPERAND_WIDTH-1:0] opAQ, opBQ;
  logic                     firstWait;
  logic                     adderStart, adderDone;
  logic [OPERAND_WIDTH:0]   adderRes;
  logic                     doneSeen;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) uArb (
    .iReq  (iReq),
    .iPtr  (ptr),
    .oGrant(arbGrant),
    .oIdx  (arbIdx),
    .oAny  (arbAny)
  );

  mp_adder #(.OPERAND_WIDTH(OPERAND_WIDTH), .ADDER_WIDTH(ADDER_WIDTH)) uAdder (
    .iClk  (iClk),
    .iRst  (iRst),
    .iStart(adderStart),
    .iA    (opAQ),
    .iB    (opBQ),
    .oRes  (adderRes),
    .oDone (adderDone)
  );

  // The first WAIT cycle ignores oDone so a stale pulse cannot complete the op
  assign doneSeen = (state == ST_WAIT) && !firstWait && adderDone;

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and adder start
  always_comb begin
    stateNext  = state;
    adderStart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arbAny) stateNext = ST_START;
        else        stateNext = ST_IDLE;
      end
      ST_START: begin
        adderStart = 1'b1;
        stateNext  = ST_WAIT;
      end
      ST_WAIT: begin
        if (doneSeen) stateNext = ST_IDLE;
        else          stateNext = ST_WAIT;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Pointer, operand latches and registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ptr       <= '0;
      wQ        <= '0;
      opAQ      <= '0;
      opBQ      <= '0;
      firstWait <= 1'b0;
      oGrant    <= '0;
      oValid    <= '0;
      oRes      <= '0;
      oBusy     <= 1'b0;
    end else begin
      oGrant    <= '0;
      oValid    <= '0;
      firstWait <= (state == ST_START);
      oBusy     <= (stateNext != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (arbAny) begin
            opAQ   <= iOpA[int'(arbIdx)*OPERAND_WIDTH +: OPERAND_WIDTH];
            opBQ   <= iOpB[int'(arbIdx)*OPERAND_WIDTH +: OPERAND_WIDTH];
            wQ     <= arbIdx;
            oGrant <= arbGrant;
            ptr    <= (arbIdx == LAST_IDX) ? '0 : arbIdx + PTR_W'(1);
          end else begin
            ptr <= ptr;
          end
        end
        ST_WAIT: begin
          if (doneSeen) begin
            oRes   <= adderRes;
            oValid <= ONE_HOT0 << wQ;
          end else begin
            oRes <= oRes;
          end
        end
        default: begin
          oRes <= oRes;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_adder_arbiter.sv
// Directed self-checking bench for mp_adder_arbiter; adder latency is 9 cycles so oValid trails oGrant by 10.
module tb_mp_adder_arbiter;

  localparam int NR = 4;
  localparam int OW = 128;
  localparam int AW = 16;

  logic              iClk = 1'b0;
  logic              iRst = 1'b1;
  logic [NR-1:0]     iReq = '0;
  logic [NR*OW-1:0]  iOpA = '0;
  logic [NR*OW-1:0]  iOpB = '0;
  logic [NR-1:0]     oGrant;
  logic [OW:0]       oRes;
  logic [NR-1:0]     oValid;
  logic              oBusy;

  int nChecks = 0;
  int nPass   = 0;

  mp_adder_arbiter #(.NUM_REQ(NR), .OPERAND_WIDTH(OW), .ADDER_WIDTH(AW)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iReq  (iReq),
    .iOpA  (iOpA),
    .iOpB  (iOpB),
    .oGrant(oGrant),
    .oRes  (oRes),
    .oValid(oValid),
    .oBusy (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic setOps(input int k, input logic [OW-1:0] a, input logic [OW-1:0] b);
    iOpA[k*OW +: OW] = a;
    iOpB[k*OW +: OW] = b;
  endtask

  task automatic doReset();
    iRst = 1'b1;
    iReq = '0;
    tick();
    iRst = 1'b0;
  endtask

  // Returns the number of cycles until oValid rises, or -1 if it never does within the budget
  task automatic waitValid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (oValid !== '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    tick();
    tick();
    nChecks++;
    if ({oGrant, oValid, oRes, oBusy} !== '0)
      $display("FAIL reset_outputs: got grant=%b valid=%b res=%h busy=%b required all zero", oGrant, oValid, oRes, oBusy);
    else nPass++;
    iRst = 1'b0;
  endtask

  task automatic test_single();
    int cyc;
    logic [OW:0] exp;
    exp = 129'h1_02020202_02020202_02020202_09090908;
    doReset();
    setOps(0, 128'h12121212_34343434_56565656_78787878, 128'hefefefef_cdcdcdcd_abababab_90909090);
    iReq = 4'b0001;
    tick();
    nChecks++;
    if (oGrant !== 4'b0001 || oBusy !== 1'b1)
      $display("FAIL single_grant: got grant=%b busy=%b required 0001 1", oGrant, oBusy);
    else nPass++;
    iReq = '0;
    waitValid(cyc);
    nChecks++;
    if (cyc !== 10) $display("FAIL single_latency: got %0d required 10", cyc);
    else nPass++;
    nChecks++;
    if (oValid !== 4'b0001 || oRes !== exp)
      $display("FAIL single_result: got valid=%b res=%h required 0001 %h", oValid, oRes, exp);
    else nPass++;
    tick();
    nChecks++;
    if (oValid !== 4'b0000 || oGrant !== 4'b0000 || oRes !== exp || oBusy !== 1'b0)
      $display("FAIL single_hold: got valid=%b grant=%b res=%h busy=%b required 0000 0000 %h 0", oValid, oGrant, oRes, oBusy, exp);
    else nPass++;
  endtask

  task automatic test_simultaneous();
    int cyc;
    doReset();
    setOps(0, 128'd0, 128'd0);
    setOps(2, 128'd5, 128'd7);
    iReq = 4'b0101;
    tick();
    nChecks++;
    if (oGrant !== 4'b0001) $display("FAIL simul_grant0: got %b required 0001", oGrant);
    else nPass++;
    iReq = 4'b0100;
    waitValid(cyc);
    nChecks++;
    if (oValid !== 4'b0001 || oRes !== 129'd0)
      $display("FAIL simul_result0: got valid=%b res=%h required 0001 0", oValid, oRes);
    else nPass++;
    tick();
    nChecks++;
    if (oGrant !== 4'b0100) $display("FAIL simul_grant2: got %b required 0100", oGrant);
    else nPass++;
    iReq = '0;
    waitValid(cyc);
    nChecks++;
    if (oValid !== 4'b0100 || oRes !== 129'd12)
      $display("FAIL simul_result2: got valid=%b res=%h required 0100 c", oValid, oRes);
    else nPass++;
  endtask

  task automatic test_fairness();
    int cyc;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    logic [NR-1:0] expOh;
    logic [OW:0]   exp;
    doReset();
    for (int k = 0; k < NR; k++)
      setOps(k, (128'(k) << 120) | 128'd3, 128'(k) << 120);
    iReq = 4'b1111;
    tick();
    for (int op = 0; op < 6; op++) begin
      expOh = 4'b0001 << order[op];
      exp   = (129'(2 * order[op]) << 120) | 129'd3;
      nChecks++;
      if (oGrant !== expOh) $display("FAIL fair_grant%0d: got %b required %b", op, oGrant, expOh);
      else nPass++;
      waitValid(cyc);
      nChecks++;
      if (cyc !== 10 || oValid !== expOh || oRes !== exp)
        $display("FAIL fair_result%0d: got cyc=%0d valid=%b res=%h required 10 %b %h", op, cyc, oValid, oRes, expOh, exp);
      else nPass++;
      if (op == 5) iReq = '0;
      tick();
    end
    nChecks++;
    if (oGrant !== 4'b0000 || oBusy !== 1'b0)
      $display("FAIL fair_drained: got grant=%b busy=%b required 0000 0", oGrant, oBusy);
    else nPass++;
  endtask

  task automatic test_carry();
    int cyc;
    logic [OW:0] exp;
    exp = {1'b1, {OW{1'b0}}};
    doReset();
    setOps(3, {OW{1'b1}}, 128'd1);
    iReq = 4'b1000;
    tick();
    nChecks++;
    if (oGrant !== 4'b1000) $display("FAIL carry_grant: got %b required 1000", oGrant);
    else nPass++;
    iReq = '0;
    waitValid(cyc);
    nChecks++;
    if (oValid !== 4'b1000 || oRes !== exp)
      $display("FAIL carry_result: got valid=%b res=%h required 1000 %h", oValid, oRes, exp);
    else nPass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    logic [OW:0] exp;
    exp = 129'h1_00000000_00000001_00000001_00000000;
    setOps(0, 128'd1, 128'd2);
    setOps(1, 128'hffffffff_00000000_ffffffff_00000001, 128'h00000001_00000000_00000001_ffffffff);
    iReq = 4'b0010;
    tick();
    iReq = '0;
    for (int i = 0; i < 4; i++) tick();
    nChecks++;
    if (oBusy !== 1'b1) $display("FAIL rstmid_busy: got %b required 1", oBusy);
    else nPass++;
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    nChecks++;
    if ({oGrant, oValid, oRes, oBusy} !== '0)
      $display("FAIL rstmid_outputs: got grant=%b valid=%b res=%h busy=%b required all zero", oGrant, oValid, oRes, oBusy);
    else nPass++;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (oValid !== '0) seen++;
    end
    nChecks++;
    if (seen !== 0) $display("FAIL rstmid_novalid: got %0d valid pulses required 0", seen);
    else nPass++;
    iReq = 4'b0011;
    tick();
    nChecks++;
    if (oGrant !== 4'b0001) $display("FAIL rstmid_ptr: got %b required 0001", oGrant);
    else nPass++;
    iReq = 4'b0010;
    waitValid(cyc);
    tick();
    nChecks++;
    if (oGrant !== 4'b0010) $display("FAIL rstmid_grant1: got %b required 0010", oGrant);
    else nPass++;
    iReq = '0;
    waitValid(cyc);
    nChecks++;
    if (oValid !== 4'b0010 || oRes !== exp)
      $display("FAIL rstmid_result1: got valid=%b res=%h required 0010 %h", oValid, oRes, exp);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    doReset();
    setOps(3, 128'd5, 128'd9);
    iReq = 4'b1000;
    tick();
    nChecks++;
    if (oGrant !== 4'b1000) $display("FAIL b2b_grant_first: got %b required 1000", oGrant);
    else nPass++;
    waitValid(cyc);
    nChecks++;
    if (cyc !== 10 || oValid !== 4'b1000 || oRes !== 129'd14)
      $display("FAIL b2b_result_first: got cyc=%0d valid=%b res=%h required 10 1000 e", cyc, oValid, oRes);
    else nPass++;
    tick();
    nChecks++;
    if (oGrant !== 4'b1000 || oValid !== 4'b0000)
      $display("FAIL b2b_regrant: got grant=%b valid=%b required 1000 0000", oGrant, oValid);
    else nPass++;
    setOps(3, 128'd100, 128'd200);
    iReq = '0;
    waitValid(cyc);
    nChecks++;
    if (cyc !== 10 || oValid !== 4'b1000 || oRes !== 129'd14)
      $display("FAIL b2b_result_second: got cyc=%0d valid=%b res=%h required 10 1000 e", cyc, oValid, oRes);
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_carry();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
